// File: rtl/fsm_master_nch.sv
// ADC conversion sequencer for up to NCH channels.
// Steps the SPI ADC master through the enabled channels (single or continuous
// sweeps), strobes the per-channel holding registers and reports EOC timeouts.
module fsm_master_nch #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stm_i,
    input  logic             cont_i,
    input  logic             stop_i,
    input  logic [NCH-1:0]   ch_en_i,
    input  logic             eoc_i,
    output logic             st_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [NCH-1:0]   hold_o,
    output logic             eos_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [SEL_W-1:0] err_ch_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD,
        S_NEXT
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             cont_q, cont_d;
    logic             stop_q, stop_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] err_ch_q, err_ch_d;
    logic [NCH-1:0]   higher;

    // Index of the lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [NCH-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (m[i] && !found) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
        end
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;

        // Enabled channels strictly above the current one in the latched mask.
        higher = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            higher[i] = mask_q[i] && (SEL_W'(i) > sel_q);
        end

        if (state_q != S_IDLE && stop_i) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (stm_i && (|ch_en_i)) begin
                    mask_d  = ch_en_i;
                    cont_d  = cont_i;
                    err_d   = 1'b0;
                    stop_d  = 1'b0;
                    sel_d   = lowest_ch(ch_en_i);
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // eoc_i takes precedence over a timeout in the same cycle.
                if (eoc_i) begin
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    err_ch_d = sel_q;
                    state_d  = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (|higher) begin
                    sel_d   = lowest_ch(higher);
                    state_d = S_START;
                end else if (cont_q && !stop_q) begin
                    mask_d = ch_en_i;
                    if (|ch_en_i) begin
                        sel_d   = lowest_ch(ch_en_i);
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        st_o   = (state_q == S_START);
        eos_o  = (state_q == S_IDLE);
        busy_o = (state_q != S_IDLE);
        hold_o = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hold_o[i] = (state_q == S_HOLD) && (sel_q == SEL_W'(i));
        end
    end

    assign sel_o    = sel_q;
    assign err_o    = err_q;
    assign err_ch_o = err_ch_q;

endmodule

// File: tb/tb_fsm_master_nch.sv
// Directed self-checking bench for fsm_master_nch (NCH=4, TIMEOUT=8).
module tb_fsm_master_nch;

    logic       clk_i;
    logic       rst_i;
    logic       stm_i;
    logic       cont_i;
    logic       stop_i;
    logic [3:0] ch_en_i;
    logic       eoc_i;
    logic       st_o;
    logic [1:0] sel_o;
    logic [3:0] hold_o;
    logic       eos_o;
    logic       busy_o;
    logic       err_o;
    logic [1:0] err_ch_o;

    int checks = 0;
    int errors = 0;

    // ADC responder configuration
    int eoc_delay   = 3;
    int withhold_ch = -1;
    int stop_sweep  = 0;

    // Sweep observation log
    logic [1:0] st_sel[16];
    logic [3:0] hold_log[16];
    int         hold_cnt[4];
    int         n_st;
    int         n_hold;
    int         cyc;
    bit         done;

    fsm_master_nch #(
        .NCH     (4),
        .SEL_W   (2),
        .TO_W    (16),
        .TIMEOUT (8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stm_i    (stm_i),
        .cont_i   (cont_i),
        .stop_i   (stop_i),
        .ch_en_i  (ch_en_i),
        .eoc_i    (eoc_i),
        .st_o     (st_o),
        .sel_o    (sel_o),
        .hold_o   (hold_o),
        .eos_o    (eos_o),
        .busy_o   (busy_o),
        .err_o    (err_o),
        .err_ch_o (err_ch_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start a sweep and act as the ADC until the sequencer is idle again.
    task automatic run_sweep(input logic [3:0] m, input logic c, input int max_cyc);
        int cd;
        int sel0;
        n_st = 0; n_hold = 0; cyc = 0; done = 0; cd = 0; sel0 = 0;
        for (int i = 0; i < 16; i++) begin
            st_sel[i]   = '0;
            hold_log[i] = '0;
        end
        for (int i = 0; i < 4; i++) hold_cnt[i] = 0;
        ch_en_i = m; cont_i = c; stm_i = 1'b1;
        tick();
        stm_i = 1'b0;
        while (!done && cyc < max_cyc) begin
            eoc_i  = 1'b0;
            stop_i = 1'b0;
            if (eos_o) begin
                done = 1;
            end else begin
                if (st_o) begin
                    if (n_st < 16) st_sel[n_st] = sel_o;
                    n_st++;
                    if (sel_o == 2'd0) begin
                        sel0++;
                        if (sel0 == stop_sweep) stop_i = 1'b1;
                    end
                    cd = eoc_delay;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0 && int'(sel_o) != withhold_ch) eoc_i = 1'b1;
                end
                if (hold_o != 4'b0000) begin
                    if (n_hold < 16) hold_log[n_hold] = hold_o;
                    n_hold++;
                    for (int i = 0; i < 4; i++) if (hold_o[i]) hold_cnt[i]++;
                end
                tick();
                cyc++;
            end
        end
        eoc_i  = 1'b0;
        stop_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; stm_i = 1'b0; cont_i = 1'b0; stop_i = 1'b0; ch_en_i = '0; eoc_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        checks++; if (st_o !== 1'b0) begin errors++; $display("FAIL reset_st: got %0b expected 0", st_o); end
        checks++; if (hold_o !== 4'b0000) begin errors++; $display("FAIL reset_hold: got %b expected 0000", hold_o); end
        checks++; if (eos_o !== 1'b1) begin errors++; $display("FAIL reset_eos: got %0b expected 1", eos_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
        checks++; if (sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_o); end
        checks++; if (err_ch_o !== 2'd0) begin errors++; $display("FAIL reset_err_ch: got %0d expected 0", err_ch_o); end
    endtask

    task automatic test_full_sweep();
        logic [3:0] exp_h[4];
        exp_h = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        eoc_delay = 3; withhold_ch = -1; stop_sweep = 0;
        run_sweep(4'b1111, 1'b0, 100);
        checks++; if (!done) begin errors++; $display("FAIL full_timeout: no return to idle within 100 cycles"); end
        checks++; if (cyc !== 24) begin errors++; $display("FAIL full_cycles: got %0d expected 24", cyc); end
        checks++; if (n_st !== 4) begin errors++; $display("FAIL full_nst: got %0d expected 4", n_st); end
        checks++; if (n_hold !== 4) begin errors++; $display("FAIL full_nhold: got %0d expected 4", n_hold); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (st_sel[i] !== 2'(i)) begin errors++; $display("FAIL full_sel[%0d]: got %0d expected %0d", i, st_sel[i], i); end
            checks++; if (hold_log[i] !== exp_h[i]) begin errors++; $display("FAIL full_hold[%0d]: got %b expected %b", i, hold_log[i], exp_h[i]); end
        end
        checks++; if (eos_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL full_eos: got eos=%0b busy=%0b expected 1/0", eos_o, busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err: got %0b expected 0", err_o); end
    endtask

    task automatic test_sparse_mask();
        run_sweep(4'b1010, 1'b0, 100);
        checks++; if (!done) begin errors++; $display("FAIL sparse_timeout: no return to idle within 100 cycles"); end
        checks++; if (cyc !== 12) begin errors++; $display("FAIL sparse_cycles: got %0d expected 12", cyc); end
        checks++; if (n_st !== 2) begin errors++; $display("FAIL sparse_nst: got %0d expected 2", n_st); end
        checks++; if (st_sel[0] !== 2'd1 || st_sel[1] !== 2'd3) begin errors++; $display("FAIL sparse_sel: got %0d,%0d expected 1,3", st_sel[0], st_sel[1]); end
        checks++; if (hold_log[0] !== 4'b0010 || hold_log[1] !== 4'b1000) begin errors++; $display("FAIL sparse_hold: got %b,%b expected 0010,1000", hold_log[0], hold_log[1]); end
        checks++; if (hold_cnt[0] !== 0 || hold_cnt[2] !== 0) begin errors++; $display("FAIL sparse_unused: got ch0=%0d ch2=%0d expected 0,0", hold_cnt[0], hold_cnt[2]); end
    endtask

    task automatic test_empty_mask();
        ch_en_i = 4'b0000; stm_i = 1'b1;
        tick();
        checks++; if (eos_o !== 1'b1 || st_o !== 1'b0) begin errors++; $display("FAIL empty_idle: got eos=%0b st=%0b expected 1/0", eos_o, st_o); end
        tick();
        stm_i = 1'b0;
        checks++; if (st_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL empty_nostart: got st=%0b busy=%0b expected 0/0", st_o, busy_o); end
    endtask

    task automatic test_latency_bounds();
        // eoc in the very first WAIT cycle
        eoc_delay = 1;
        run_sweep(4'b0100, 1'b0, 100);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL minlat_cycles: got %0d expected 4", cyc); end
        checks++; if (hold_log[0] !== 4'b0100 || n_hold !== 1) begin errors++; $display("FAIL minlat_hold: got %b n=%0d expected 0100 n=1", hold_log[0], n_hold); end
        // eoc coincides with the last allowed WAIT cycle: no error
        eoc_delay = 8;
        run_sweep(4'b0010, 1'b0, 100);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL tie_cycles: got %0d expected 11", cyc); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tie_err: got %0b expected 0", err_o); end
        checks++; if (hold_log[0] !== 4'b0010 || n_hold !== 1) begin errors++; $display("FAIL tie_hold: got %b n=%0d expected 0010 n=1", hold_log[0], n_hold); end
        eoc_delay = 3;
    endtask

    task automatic test_timeout();
        withhold_ch = 2;
        run_sweep(4'b1111, 1'b0, 100);
        checks++; if (cyc !== 28) begin errors++; $display("FAIL to_cycles: got %0d expected 28", cyc); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err: got %0b expected 1", err_o); end
        checks++; if (err_ch_o !== 2'd2) begin errors++; $display("FAIL to_err_ch: got %0d expected 2", err_ch_o); end
        checks++; if (hold_cnt[2] !== 0 || n_hold !== 3) begin errors++; $display("FAIL to_hold: got ch2=%0d n=%0d expected 0,3", hold_cnt[2], n_hold); end
        checks++; if (n_st !== 4 || st_sel[3] !== 2'd3) begin errors++; $display("FAIL to_continue: got n_st=%0d last_sel=%0d expected 4,3", n_st, st_sel[3]); end
        withhold_ch = -1;
        run_sweep(4'b0001, 1'b0, 100);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b expected 0", err_o); end
        checks++; if (err_ch_o !== 2'd2) begin errors++; $display("FAIL to_errch_keep: got %0d expected 2", err_ch_o); end
        checks++; if (cyc !== 6 || n_hold !== 1) begin errors++; $display("FAIL to_after: got cyc=%0d n=%0d expected 6,1", cyc, n_hold); end
    endtask

    task automatic test_continuous_stop();
        logic [3:0] exp_h[6];
        exp_h = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        stop_sweep = 3;
        run_sweep(4'b0011, 1'b1, 200);
        stop_sweep = 0;
        checks++; if (!done) begin errors++; $display("FAIL cont_timeout: no return to idle within 200 cycles"); end
        checks++; if (n_hold !== 6) begin errors++; $display("FAIL cont_nhold: got %0d expected 6", n_hold); end
        checks++; if (cyc !== 36) begin errors++; $display("FAIL cont_cycles: got %0d expected 36", cyc); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (hold_log[i] !== exp_h[i]) begin errors++; $display("FAIL cont_hold[%0d]: got %b expected %b", i, hold_log[i], exp_h[i]); end
        end
        checks++; if (eos_o !== 1'b1) begin errors++; $display("FAIL cont_idle: got %0b expected 1", eos_o); end
    endtask

    task automatic test_reset_in_wait();
        ch_en_i = 4'b1100; cont_i = 1'b0; stm_i = 1'b1;
        tick();
        stm_i = 1'b0;
        checks++; if (st_o !== 1'b1 || sel_o !== 2'd2) begin errors++; $display("FAIL rw_start: got st=%0b sel=%0d expected 1,2", st_o, sel_o); end
        tick();
        checks++; if (busy_o !== 1'b1 || st_o !== 1'b0) begin errors++; $display("FAIL rw_wait: got busy=%0b st=%0b expected 1,0", busy_o, st_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if (eos_o !== 1'b1 || sel_o !== 2'd0) begin errors++; $display("FAIL rw_idle: got eos=%0b sel=%0d expected 1,0", eos_o, sel_o); end
        checks++; if (hold_o !== 4'b0000 || st_o !== 1'b0) begin errors++; $display("FAIL rw_outs: got hold=%b st=%0b expected 0000,0", hold_o, st_o); end
        eoc_i = 1'b1;
        tick();
        eoc_i = 1'b0;
        tick();
        checks++; if (hold_o !== 4'b0000 || eos_o !== 1'b1 || st_o !== 1'b0) begin errors++; $display("FAIL rw_eoc_ignored: got hold=%b eos=%0b st=%0b expected 0000,1,0", hold_o, eos_o, st_o); end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_sparse_mask();
        test_empty_mask();
        test_latency_bounds();
        test_timeout();
        test_continuous_stop();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_master_nch.md
Name: fsm_master_nch

Overview:
Parametrised successor to the 2-channel ADC conversion sequencer. It steps the SPI ADC controller through up to NCH channels selected by an enable mask, and raises a one-hot hold strobe so each channel's result register captures its conversion. It adds single-sweep and continuous modes, a graceful stop request, and an end-of-conversion timeout with error reporting. It sits between the top-level control logic and the SPI ADC master plus the per-channel holding registers.

Parameters:
NCH, 4, number of ADC channels (2..8)
SEL_W, 2, width of channel select; must satisfy 2**SEL_W >= NCH
TO_W, 16, width of the timeout counter
TIMEOUT, 1000, cycles in WAIT without eoc_i before a channel is abandoned (1..2**TO_W-1)

Ports:
clk_i  in  1  system clock; all logic is on the rising edge
rst_i  in  1  synchronous reset, active-high
stm_i  in  1  start-sweep request, sampled only in IDLE
cont_i  in  1  continuous mode, latched when stm_i is accepted
stop_i  in  1  request to end continuous operation after the current sweep
ch_en_i  in  NCH  channel enable mask, latched at the start of each sweep
eoc_i  in  1  end of conversion from the SPI ADC master
st_o  out  1  one-cycle conversion start pulse to the SPI ADC master
sel_o  out  SEL_W  channel currently being converted
hold_o  out  NCH  one-hot, one-cycle capture strobe for the result register of channel sel_o
eos_o  out  1  end of sequence / idle level, high only in IDLE
busy_o  out  1  inverse of eos_o
err_o  out  1  sticky timeout flag
err_ch_o  out  SEL_W  channel of the most recent timeout

Behaviour:
- Reset is synchronous: rst_i high at a rising edge forces IDLE, sel_o=0, err_o=0, err_ch_o=0, the latched mask=0, cont=0, the stop flag=0 and the timeout count=0. The reset output values are st_o=0, hold_o=0, eos_o=1, busy_o=0. Reset during a sweep aborts it immediately, with no hold strobe.
- st_o, hold_o, eos_o and busy_o are Moore outputs decoded from the state. sel_o, err_o and err_ch_o are registered.
- States: IDLE, START, WAIT, HOLD, NEXT.
- IDLE: eos_o=1. If stm_i=1 and ch_en_i!=0 at an edge:
  - latch the mask and cont_i;
  - clear err_o and the stop flag;
  - set sel_o to the lowest enabled channel;
  - go to START.
  - stm_i with ch_en_i==0 is ignored and the block stays in IDLE.
- START: st_o=1 for exactly one cycle; clear the timeout count; go to WAIT.
- WAIT:
  - If eoc_i=1, go to HOLD.
  - Otherwise, if count==TIMEOUT-1, set err_o=1, set err_ch_o=sel_o and go to NEXT without a hold strobe.
  - Otherwise increment the count.
  - If eoc_i=1 and the timeout condition occur in the same cycle, eoc_i wins and no error is raised.
- HOLD: hold_o[sel_o]=1 for one cycle; go to NEXT.
- NEXT, in priority order:
  - If a higher-numbered enabled channel exists in the latched mask, set sel_o to the nearest one and go to START.
  - Else, if cont=1 and the stop flag=0: re-latch ch_en_i. If the new mask is non-zero, set sel_o to its lowest channel and go to START. If it is zero, go to IDLE.
  - Else go to IDLE with sel_o unchanged.
- The stop flag is set by stop_i=1 in any non-IDLE state. It is cleared on reset and on stm_i acceptance. A pending stop never truncates a sweep.
- eoc_i is ignored outside WAIT. stm_i is ignored outside IDLE.
- Per-channel latency: 1 (START) + k (WAIT, eoc_i arriving after k cycles, k>=1) + 1 (HOLD) + 1 (NEXT). Sweep timing: stm_i accepted at edge 0, st_o high in cycle 1, eos_o returns high one cycle after the last NEXT.
- Mask bits at index >= NCH do not exist. sel_o never exceeds NCH-1.

Test Plan:
- NCH=4, ch_en_i=4'b1111, cont_i=0, eoc_i 3 cycles after each st_o -> four st_o pulses with sel_o 0,1,2,3; hold_o 0001,0010,0100,1000 each for one cycle; eos_o high again after the sweep; err_o=0.
- ch_en_i=4'b1010 -> exactly two conversions with sel_o=1 then sel_o=3; hold_o=0010 then 1000; channels 0 and 2 never strobed.
- ch_en_i=0 with stm_i=1 -> stays in IDLE, eos_o=1, no st_o pulse.
- TIMEOUT=8, eoc_i withheld on channel 2 -> after 8 WAIT cycles err_o=1 and err_ch_o=2, no hold_o[2], sweep continues to channel 3; the next accepted stm_i clears err_o.
- cont_i=1, mask 4'b0011, stop_i pulsed during the first sel_o=0 conversion of the third sweep -> third sweep completes on channel 1, then IDLE; exactly 6 hold strobes in total.
- rst_i asserted in WAIT -> next cycle IDLE, sel_o=0, hold_o=0, st_o=0; an eoc_i arriving afterwards is ignored.
